// File: rtl/block_drawer_pkg.sv
// Shared definitions for the block drawing stage: FSM encoding and screen constants.
// Other game stages import this to stay consistent with the drawer.
package block_drawer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int HEIGHT   = 4;
  localparam logic [2:0] BG_COLOUR = 3'b000;

  // A column is visible when the full-width sum lies left of the screen edge.
  function automatic logic on_screen(input logic [8:0] col, input int screen_w);
    return (int'(col) < screen_w);
  endfunction

endpackage

// File: rtl/block_drawer_scanner.sv
// Row-major rectangle walker. cx/ry give the coordinate to present in the next
// cycle; last flags that the coordinate presented now is the final one.
module rect_scanner #(
  parameter int CW = 8,
  parameter int RW = 7
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          go,
  input  logic [CW-1:0] width,
  input  logic [RW-1:0] height,
  output logic [CW-1:0] cx,
  output logic [RW-1:0] ry,
  output logic          last
);

  logic [CW-1:0] cx_q, cx_d;
  logic [RW-1:0] ry_q, ry_d;
  logic [CW-1:0] w_q, w_d;
  logic [RW-1:0] h_q, h_d;
  logic          last_q, last_d;

  always_comb begin
    cx_d   = cx_q;
    ry_d   = ry_q;
    w_d    = w_q;
    h_d    = h_q;
    last_d = last_q;
    if (go) begin
      cx_d   = '0;
      ry_d   = '0;
      w_d    = width;
      h_d    = height;
      last_d = (width == CW'(1)) && (height == RW'(1));
    end else if (!last_q) begin
      if (cx_q == w_q - CW'(1)) begin
        cx_d = '0;
        ry_d = ry_q + RW'(1);
      end else begin
        cx_d = cx_q + CW'(1);
      end
      last_d = (cx_d == w_q - CW'(1)) && (ry_d == h_q - RW'(1));
    end
  end

  // Out of reset the walker sits parked on "last" so it never advances idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx_q   <= '0;
      ry_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      last_q <= 1'b1;
    end else begin
      cx_q   <= cx_d;
      ry_q   <= ry_d;
      w_q    <= w_d;
      h_q    <= h_d;
      last_q <= last_d;
    end
  end

  assign cx   = cx_d;
  assign ry   = ry_d;
  assign last = last_q;

endmodule

// File: rtl/block_drawer.sv
// Erases the previous block rectangle, then draws the new one, streaming one
// registered pixel per cycle to the VGA adapter.
module block_drawer #(
  parameter int         HEIGHT    = block_drawer_pkg::HEIGHT,
  parameter int         SCREEN_W  = block_drawer_pkg::SCREEN_W,
  parameter logic [2:0] BG_COLOUR = block_drawer_pkg::BG_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [7:0] width_in,
  input  logic [2:0] colour_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  import block_drawer_pkg::*;

  state_e     state_q, state_d;
  logic [7:0] new_x_q, new_x_d;
  logic [6:0] new_y_q, new_y_d;
  logic [7:0] new_w_q, new_w_d;
  logic [2:0] new_col_q, new_col_d;
  logic [7:0] prev_x_q, prev_x_d;
  logic [6:0] prev_y_q, prev_y_d;
  logic [7:0] prev_w_q, prev_w_d;
  logic       prev_valid_q, prev_valid_d;

  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       scan_go;
  logic [7:0] scan_w;
  logic [7:0] scan_cx;
  logic [6:0] scan_ry;
  logic       scan_last;

  logic       in_phase;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] col_sum;

  rect_scanner #(
    .CW(8),
    .RW(7)
  ) u_scanner (
    .clk   (clk),
    .resetn(resetn),
    .go    (scan_go),
    .width (scan_w),
    .height(7'(HEIGHT)),
    .cx    (scan_cx),
    .ry    (scan_ry),
    .last  (scan_last)
  );

  always_comb begin
    state_d      = state_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_w_d      = new_w_q;
    new_col_d    = new_col_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_w_d     = prev_w_q;
    prev_valid_d = prev_valid_q;
    scan_go      = 1'b0;
    scan_w       = new_w_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          new_x_d   = x_in;
          new_y_d   = y_in;
          new_w_d   = width_in;
          new_col_d = colour_in;
          if (prev_valid_q && (prev_w_q != '0)) begin
            state_d = ERASE;
            scan_go = 1'b1;
            scan_w  = prev_w_q;
          end else if (width_in != '0) begin
            state_d = DRAW;
            scan_go = 1'b1;
            scan_w  = width_in;
          end else begin
            state_d = DONE;
          end
        end
      end
      ERASE: begin
        if (scan_last) begin
          if (new_w_q != '0) begin
            state_d = DRAW;
            scan_go = 1'b1;
            scan_w  = new_w_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      DRAW: begin
        if (scan_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        prev_x_d     = new_x_q;
        prev_y_d     = new_y_q;
        prev_w_d     = new_w_q;
        prev_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel outputs are computed from next state so the first pixel appears
  // the cycle right after start is accepted.
  always_comb begin
    in_phase     = (state_d == ERASE) || (state_d == DRAW);
    base_x       = (state_d == ERASE) ? prev_x_q : new_x_d;
    base_y       = (state_d == ERASE) ? prev_y_q : new_y_d;
    col_sum      = {1'b0, base_x} + {1'b0, scan_cx};
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    if (in_phase) begin
      vga_x_d      = col_sum[7:0];
      vga_y_d      = base_y + scan_ry;
      vga_colour_d = (state_d == ERASE) ? BG_COLOUR : new_col_d;
    end
    plot_d = in_phase && on_screen(col_sum, SCREEN_W);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_w_q      <= '0;
      new_col_q    <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_w_q     <= '0;
      prev_valid_q <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      new_w_q      <= new_w_d;
      new_col_q    <= new_col_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_w_q     <= prev_w_d;
      prev_valid_q <= prev_valid_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
